// File: rtl/servo_pwm.sv
// Multi-channel RC servo/ESC PWM generator on a 1 MHz clock with double-buffered commands.
// Optional frame watchdog with failsafe commands when SERVO_PWM_FAILSAFE_EN is defined.
module servo_pwm #(
    parameter int unsigned NUM_CH          = 4,
    parameter int unsigned FRAME_US        = 20000,
    parameter int unsigned OFFSET_US       = 988,
    parameter int unsigned RST_VAL         = 512,
    parameter int unsigned FAILSAFE_FRAMES = 10
) (
    input  logic              clk_1M,
    input  logic              rst,
    input  logic              en,
    input  logic              cmd_wr,
    input  logic [2:0]        cmd_ch,
    input  logic [9:0]        cmd_data,
    output logic [NUM_CH-1:0] pwm_out,
    output logic              frame_tick,
    output logic              failsafe
);

    localparam int unsigned     CtrW   = $clog2(FRAME_US);
    localparam logic [CtrW-1:0] CtrMax = CtrW'(FRAME_US - 1);
    localparam logic [CtrW-1:0] Offset = CtrW'(OFFSET_US);
    localparam logic [9:0]      RstVal = 10'(RST_VAL);

    logic [CtrW-1:0]   ctr_q, ctr_d;
    logic [9:0]        shadow_q [NUM_CH];
    logic [9:0]        shadow_d [NUM_CH];
    logic [9:0]        active_q [NUM_CH];
    logic [9:0]        active_d [NUM_CH];
    logic              en_act_q, en_act_d;
    logic [NUM_CH-1:0] pwm_q, pwm_d;
    logic              tick_q, tick_d;
    logic              latch;
    logic              wr_ok;
    logic              fs_load;

    assign wr_ok = cmd_wr && (32'(cmd_ch) < NUM_CH);
    assign latch = (ctr_q == CtrMax);

`ifdef SERVO_PWM_FAILSAFE_EN
    localparam int unsigned    WdW   = $clog2(FAILSAFE_FRAMES + 1);
    localparam logic [WdW-1:0] WdMax = WdW'(FAILSAFE_FRAMES);

    logic [WdW-1:0] wd_q, wd_d;
    logic           fs_q, fs_d;

    // Latch edges since the last accepted write; saturates at WdMax while failsafe holds.
    always_comb begin
        wd_d    = wd_q;
        fs_d    = fs_q;
        fs_load = 1'b0;
        if (wr_ok) begin
            wd_d = '0;
            fs_d = 1'b0;
        end else if (latch) begin
            if (wd_q == WdMax) begin
                fs_load = 1'b1;
                fs_d    = 1'b1;
            end else begin
                wd_d = wd_q + WdW'(1);
            end
        end
    end

    always_ff @(posedge clk_1M) begin
        if (rst) begin
            wd_q <= '0;
            fs_q <= 1'b0;
        end else begin
            wd_q <= wd_d;
            fs_q <= fs_d;
        end
    end

    assign failsafe = fs_q;
`else
    assign fs_load  = 1'b0;
    assign failsafe = 1'b0;
`endif

    // Outputs are computed for the upcoming cycle so they rise together on the latch edge.
    always_comb begin
        ctr_d    = latch ? '0 : ctr_q + CtrW'(1);
        en_act_d = latch ? en : en_act_q;
        tick_d   = (ctr_d == '0);
        pwm_d    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            shadow_d[i] = (wr_ok && (cmd_ch == 3'(i))) ? cmd_data : shadow_q[i];
            active_d[i] = latch ? (fs_load ? RstVal : shadow_d[i]) : active_q[i];
            pwm_d[i]    = en_act_d && (ctr_d < (Offset + CtrW'(active_d[i])));
        end
    end

    always_ff @(posedge clk_1M) begin
        if (rst) begin
            ctr_q    <= '0;
            en_act_q <= 1'b0;
            pwm_q    <= '0;
            tick_q   <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                shadow_q[i] <= RstVal;
                active_q[i] <= RstVal;
            end
        end else begin
            ctr_q    <= ctr_d;
            en_act_q <= en_act_d;
            pwm_q    <= pwm_d;
            tick_q   <= tick_d;
            for (int i = 0; i < NUM_CH; i++) begin
                shadow_q[i] <= shadow_d[i];
                active_q[i] <= active_d[i];
            end
        end
    end

    assign pwm_out    = pwm_q;
    assign frame_tick = tick_q;

endmodule
